pe_weight_loader: RTL and testbench
===================================

# pe_weight_loader

Sequencer that drives the PE weight-write port (`weight_wr_en` / `weight_wr_addr` / `weight_wr_data`) of `pe_incha_single`, replacing bench-driven task writes.
- Consumes a flat 16-bit word stream under a valid/ready handshake.
- Emits one addressed write per word: all kernel weights in channel-major order, then one bias per output channel.
- Sits between the weight DMA/stream source and the PE; after `done`, the PE is fully loaded.

## Interface
- `IN_CHANNEL`, 2, input channels of the target PE
- `OUT_CHANNEL`, 4, output channels; must be ≤ 256
- `KERNEL_0`, 3, kernel height
- `KERNEL_1`, 3, kernel width
- `KERNEL_WORDS` (derived), `KERNEL_0*KERNEL_1*IN_CHANNEL`, kernel positions per output channel; must be ≤ 256

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request to begin a full load; ignored unless idle
- `s_data`  in  16  stream word
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  loader accepts `s_data` this cycle
- `weight_wr_en`  out  1  write strobe to PE, one cycle per word
- `weight_wr_addr`  out  32  `{type[7:0], out_ch[7:0], pos[7:0], 8'h00}`; type is 8'h00 for kernel, 8'h01 for bias; pos is 0 for bias
- `weight_wr_data`  out  16  kernel: `{8'h00, s_data[7:0]}`; bias: `s_data[15:0]`
- `busy`  out  1  load in progress (state KERNEL or BIAS)
- `done`  out  1  one-cycle pulse after the final bias write

## Operation
States: IDLE, KERNEL, BIAS, DONE.
- **IDLE**
  - `s_ready`=0.
  - On `start`=1: clear `oc`/`pos`, go to KERNEL.
- **KERNEL**
  - `s_ready`=1.
  - On accept (`s_valid && s_ready`): register a write with type 00, `out_ch`=`oc`, `pos`=`pos`. Upper data byte is forced to 0 and `s_data[15:8]` is discarded.
  - Then `pos`++. When `pos` = `KERNEL_WORDS`-1: `pos`←0 and `oc`++.
  - When `oc` = `OUT_CHANNEL`-1 and `pos` = `KERNEL_WORDS`-1: `oc`←0, go to BIAS.
- **BIAS**
  - `s_ready`=1.
  - On accept: register a write with type 01, `out_ch`=`oc`, `pos`=0, full 16-bit data, then `oc`++.
  - On the accept with `oc` = `OUT_CHANNEL`-1: go to DONE.
- **DONE**
  - `s_ready`=0, `done`=1 for exactly this cycle; next state IDLE.
- Word order per load: `OUT_CHANNEL*KERNEL_WORDS` kernel words (oc outer, pos inner), then `OUT_CHANNEL` bias words (ascending oc). Total words = `OUT_CHANNEL*(KERNEL_WORDS+1)`.
- `s_valid`=0 in KERNEL/BIAS stalls the load: no write, counters hold, state holds. There is no timeout.
- `start` while busy or in DONE has no effect.
- Stream words presented while IDLE are not consumed (`s_ready`=0).

## Timing
- **Reset:** `rst_n`=0 at a rising edge forces, at that edge:
  - state IDLE, counters 0
  - `s_ready`=0, `weight_wr_en`=0, `weight_wr_addr`=0, `weight_wr_data`=0, `busy`=0, `done`=0
- **Reset mid-load:** abandons the load with no further writes. Already-written PE entries are not rolled back.
- **Write latency:** a word accepted at edge k appears with `weight_wr_en`=1 in the cycle after edge k, for exactly one cycle unless another word is accepted at edge k+1.
- **Throughput:** back-to-back accepts give back-to-back writes, 1 word/cycle, with no bubble at the KERNEL→BIAS transition.
- **Hold:** `weight_wr_addr`/`weight_wr_data` hold their last value while `weight_wr_en`=0.
- `s_ready` is a function of state only, with no combinational path from `s_valid`.
- **Start latency:** `start` at edge s gives `busy`=1 and `s_ready`=1 from the cycle after edge s.
- **Completion:** final bias accepted at edge N gives:
  - last write strobe in cycle N+1, with state DONE and `done`=1 in that same cycle;
  - `busy`=0 from cycle N+1;
  - state IDLE from cycle N+2.
- A new `start` is honored in the `done` cycle's successor (IDLE) at the earliest.

## Test plan
- **Full load (defaults):** `start`, then 76 words with `s_valid` held high. Kernel value = 10+i for stream index i<72; biases 100, 1000, −50 (16'hFFCE), 32767.
  - Exactly 76 strobes.
  - Write 0 has addr 32'h0000_0000, data 16'h000A.
  - Write 17 has addr 32'h0000_1100.
  - Write 18 has addr 32'h0001_0000.
  - Write 71 has addr 32'h0003_1100.
  - Write 72 has addr 32'h0100_0000, data 16'h0064.
  - Write 74 has data 16'hFFCE.
  - Write 75 has addr 32'h0103_0000, data 16'h7FFF.
  - `done` pulses once, one cycle after the edge accepting word 75.
- **Kernel byte masking:** kernel word 16'hABA5 → `weight_wr_data`=16'h00A5. A bias word 16'hABA5 passes through unchanged.
- **Stalls:** randomly deassert `s_valid` (e.g. every 3rd cycle) → identical address/data sequence as the full-load case, no strobe in stall cycles, counters frozen.
- **Ignored inputs:** with `s_valid`=1 while IDLE → `s_ready`=0, no strobe. A second `start` mid-load → sequence unchanged, single `done`.
- **Reset mid-load:** `rst_n`=0 after 30 accepted words →
  - next cycle: `weight_wr_en`=0, `busy`=0, addr/data=0;
  - a subsequent `start` restarts at addr 32'h0000_0000.
- **Back-to-back loads:** `start` in the cycle after `done` → second full 76-write sequence identical to the first.

Source files
------------

// File: rtl/pe_weight_loader.sv
// pe_weight_loader
//   Turns a flat 16-bit weight stream into addressed writes on the weight
//   port of pe_incha_single. A load consists of every kernel word
//   (out channel outer, kernel position inner), followed by one bias word per
//   out channel in ascending order.
//
// Handshake: a stream word is transferred on a rising edge where
//   s_valid && s_ready. s_ready depends only on the state (high in KERNEL and
//   BIAS), so there is no combinational path from s_valid to s_ready. s_valid
//   may drop at any time; that simply stalls the load.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a load (only honoured in IDLE)
//   s_data/s_valid  stream word and its valid
//   s_ready         loader accepts s_data this cycle
//   weight_wr_en    registered write strobe, one cycle per accepted word
//   weight_wr_addr  {type, out_ch, pos, 8'h00}; type 00 kernel, 01 bias
//   weight_wr_data  kernel: {8'h00, low byte}; bias: full 16 bits
//   busy            state is KERNEL or BIAS
//   done            high for the single DONE cycle after the last bias write
//   dbg_state       current FSM state, for checkers and debug
module pe_weight_loader #(
  parameter int IN_CHANNEL  = 2,
  parameter int OUT_CHANNEL = 4,
  parameter int KERNEL_0    = 3,
  parameter int KERNEL_1    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weight_wr_en,
  output logic [31:0] weight_wr_addr,
  output logic [15:0] weight_wr_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam int KERNEL_WORDS = KERNEL_0 * KERNEL_1 * IN_CHANNEL;
  localparam logic [7:0] OC_LAST  = 8'(OUT_CHANNEL - 1);
  localparam logic [7:0] POS_LAST = 8'(KERNEL_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_KERNEL = 2'd1,
    S_BIAS   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [7:0]  oc, oc_next;
  logic [7:0]  pos, pos_next;
  logic        wr_en_next;
  logic [31:0] wr_addr_next;
  logic [15:0] wr_data_next;
  logic        accept;

  assign s_ready   = (state == S_KERNEL) || (state == S_BIAS);
  assign busy      = s_ready;
  assign done      = (state == S_DONE);
  assign accept    = s_valid && s_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      oc             <= 8'd0;
      pos            <= 8'd0;
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= 32'd0;
      weight_wr_data <= 16'd0;
    end else begin
      state          <= state_next;
      oc             <= oc_next;
      pos            <= pos_next;
      weight_wr_en   <= wr_en_next;
      weight_wr_addr <= wr_addr_next;
      weight_wr_data <= wr_data_next;
    end
  end

  // Address/data registers only update on an accept, so they hold the last
  // write while the strobe is low.
  always_comb begin
    state_next   = state;
    oc_next      = oc;
    pos_next     = pos;
    wr_en_next   = 1'b0;
    wr_addr_next = weight_wr_addr;
    wr_data_next = weight_wr_data;
    case (state)
      S_IDLE: begin
        if (start) begin
          oc_next    = 8'd0;
          pos_next   = 8'd0;
          state_next = S_KERNEL;
        end
      end
      S_KERNEL: begin
        if (accept) begin
          wr_en_next   = 1'b1;
          wr_addr_next = {8'h00, oc, pos, 8'h00};
          wr_data_next = {8'h00, s_data[7:0]};
          if (pos == POS_LAST) begin
            pos_next = 8'd0;
            if (oc == OC_LAST) begin
              // Straight into BIAS so the first bias word can follow the
              // last kernel word on the very next edge.
              oc_next    = 8'd0;
              state_next = S_BIAS;
            end else begin
              oc_next = oc + 8'd1;
            end
          end else begin
            pos_next = pos + 8'd1;
          end
        end
      end
      S_BIAS: begin
        if (accept) begin
          wr_en_next   = 1'b1;
          wr_addr_next = {8'h01, oc, 8'h00, 8'h00};
          wr_data_next = s_data;
          if (oc == OC_LAST) begin
            oc_next    = 8'd0;
            state_next = S_DONE;
          end else begin
            oc_next = oc + 8'd1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_weight_loader.sv
module tb_pe_weight_loader;

  localparam int OC = 4;
  localparam int KW = 2 * 3 * 3;
  localparam int NW = OC * (KW + 1);

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weight_wr_en;
  logic [31:0] weight_wr_addr;
  logic [15:0] weight_wr_data;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  pe_weight_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .weight_wr_en   (weight_wr_en),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_data (weight_wr_data),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_q[$];
  logic [47:0] wr_log[$];
  logic [15:0] words[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops one expected {addr,data}; done must coincide
  // with the last write of a load.
  always @(negedge clk) begin : monitor
    logic [47:0] e;
    if (weight_wr_en === 1'b1) begin
      wr_log.push_back({weight_wr_addr, weight_wr_data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected none", {weight_wr_addr, weight_wr_data});
      end else begin
        e = exp_q.pop_front();
        check("write", 64'({weight_wr_addr, weight_wr_data}), 64'(e));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_with_last_write", 64'({weight_wr_en, (exp_q.size() == 0)}), 64'(2'b11));
    end
  end

  // ---------------- reference model ----------------
  // mode 0: random words, 1: directed test-plan values, 2: random with
  // 16'hABA5 as first kernel and first bias word.
  task automatic build_load(input int mode);
    words.delete();
    for (int i = 0; i < OC * KW; i++)
      words.push_back((mode == 1) ? 16'(10 + i) : 16'($urandom));
    if (mode == 1) begin
      words.push_back(16'd100);
      words.push_back(16'd1000);
      words.push_back(16'hFFCE);
      words.push_back(16'd32767);
    end else begin
      for (int i = 0; i < OC; i++) words.push_back(16'($urandom));
    end
    if (mode == 2) begin
      words[0]       = 16'hABA5;
      words[OC * KW] = 16'hABA5;
    end
    for (int o = 0; o < OC; o++)
      for (int p = 0; p < KW; p++)
        exp_q.push_back({8'h00, 8'(o), 8'(p), 8'h00, 8'h00, words[o * KW + p][7:0]});
    for (int o = 0; o < OC; o++)
      exp_q.push_back({8'h01, 8'(o), 16'h0000, words[OC * KW + o]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 64'(busy), 64'(1'b1));
    check("start_s_ready", 64'(s_ready), 64'(1'b1));
  endtask

  // Streams words[0 .. n-1]; returns at posedge+1 of the last accept.
  task automatic stream(input int stall_pct, input int n, input bit extra_start, output bit ok);
    bit acc;
    int t;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < 32'(stall_pct)) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = words[i];
      if (extra_start && i == 20) start = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        t++;
      end
      start = 1'b0;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no s_ready expected accept of word %0d", i);
        ok = 1'b0;
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic run_load(input int mode, input int stall_pct, input bit extra_start);
    int d0;
    int w0;
    bit ok;
    d0 = done_cnt;
    w0 = wr_log.size();
    build_load(mode);
    do_start();
    stream(stall_pct, NW, extra_start, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    check("done_after_last", 64'(done), 64'(1'b1));
    check("busy_after_last", 64'(busy), 64'(1'b0));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(1'b0));
    check("back_to_idle", 64'(dbg_state), 64'(2'd0));
    check("done_count", 64'(done_cnt - d0), 64'(1));
    check("write_count", 64'(wr_log.size() - w0), 64'(NW));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 64'(weight_wr_en), 64'(0));
    check("rst_addr", 64'(weight_wr_addr), 64'(0));
    check("rst_data", 64'(weight_wr_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stream words while IDLE are not consumed.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    repeat (4) begin
      @(posedge clk); #1;
      check("idle_s_ready", 64'(s_ready), 64'(0));
      check("idle_wr_en", 64'(weight_wr_en), 64'(0));
    end
    s_valid = 1'b0;

    // Directed full load with literal addresses/data.
    run_load(1, 0, 1'b0);
    if (wr_log.size() >= NW) begin
      check("w0", 64'(wr_log[0]), 64'({32'h0000_0000, 16'h000A}));
      check("w17_addr", 64'(wr_log[17][47:16]), 64'(32'h0000_1100));
      check("w18_addr", 64'(wr_log[18][47:16]), 64'(32'h0001_0000));
      check("w71_addr", 64'(wr_log[71][47:16]), 64'(32'h0003_1100));
      check("w72", 64'(wr_log[72]), 64'({32'h0100_0000, 16'h0064}));
      check("w74_data", 64'(wr_log[74][15:0]), 64'(16'hFFCE));
      check("w75", 64'(wr_log[75]), 64'({32'h0103_0000, 16'h7FFF}));
    end else begin
      checks++;
      errors++;
      $display("FAIL first_load_len: got %0d expected %0d", wr_log.size(), NW);
    end

    // Kernel byte masking; starts in the cycle after done's successor.
    begin
      int w0;
      w0 = wr_log.size();
      run_load(2, 0, 1'b0);
      if (wr_log.size() >= w0 + NW) begin
        check("mask_kernel", 64'(wr_log[w0][15:0]), 64'(16'h00A5));
        check("mask_bias", 64'(wr_log[w0 + OC * KW][15:0]), 64'(16'hABA5));
      end
    end

    // Directed sequence again with stalls, then with a redundant start.
    run_load(1, 33, 1'b0);
    run_load(0, 0, 1'b1);

    // Reset after 30 accepted words.
    build_load(0);
    do_start();
    stream(20, 30, 1'b0, ok);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_wr_en", 64'(weight_wr_en), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_addr", 64'(weight_wr_addr), 64'(0));
    check("midrst_data", 64'(weight_wr_data), 64'(0));
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(0, 0, 1'b0);

    // Random loads with random stall rates.
    for (int k = 0; k < 4; k++) run_load(0, int'($urandom_range(50)), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
